// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, sent as start bit, data LSB first,
// optional parity bit and 1 or 2 stop bits, with a fixed clk divider setting the bit time.
module uart_tx #(
  parameter int UART_CLK_CNT = 434,
  parameter int data_width   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  uart_tx_pin,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CW = (UART_CLK_CNT > 1) ? $clog2(UART_CLK_CNT) : 1;
  localparam int BW = $clog2(data_width + 1);
  localparam logic [CW-1:0] CLK_LAST  = CW'(UART_CLK_CNT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(data_width - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         clk_cnt_reg, clk_cnt_next;
  logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
  logic [data_width-1:0] shift_reg, shift_next;
  logic                  parity_reg, parity_next;
  logic                  pin_reg, pin_next;
  logic                  bit_end, last_stop, accept;

  assign bit_end     = (clk_cnt_reg == CLK_LAST);
  assign last_stop   = (state_reg == STOP) && bit_end && (bit_cnt_reg == STOP_LAST);
  assign tx_ready    = (state_reg == IDLE) || last_stop;
  assign accept      = tx_valid && tx_ready;
  assign tx_done     = last_stop;
  assign tx_busy     = (state_reg != IDLE);
  assign uart_tx_pin = pin_reg;

  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = clk_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;

    if (state_reg != IDLE) begin
      clk_cnt_next = bit_end ? '0 : clk_cnt_reg + CW'(1);
    end

    case (state_reg)
      IDLE: ;
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == DATA_LAST) begin
            bit_cnt_next = '0;
            state_next   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_reg == STOP_LAST) state_next = IDLE;
          else bit_cnt_next = bit_cnt_reg + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // An accept in the final stop cycle overrides the return to IDLE (back-to-back frames).
    if (accept) begin
      state_next   = START;
      clk_cnt_next = '0;
      bit_cnt_next = '0;
      shift_next   = tx_data;
      parity_next  = (^tx_data) ^ (PARITY_ODD != 0);
    end

    // The line is registered, so it is driven from the state being entered.
    case (state_next)
      START:   pin_next = 1'b0;
      DATA:    pin_next = shift_next[0];
      PARITY:  pin_next = parity_next;
      default: pin_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      pin_reg     <= 1'b1;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      pin_reg     <= pin_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E1, 8O1, 7N2) at 4 clocks per bit, checked
// against a bit-list frame model expanded to per-cycle waveforms.
module tb_uart_tx;
  localparam int NDUT = 4;
  localparam int CPB  = 4;

  logic            clk;
  logic [NDUT-1:0] rst_v;
  logic [NDUT-1:0] valid_v;
  logic [8:0]      data_v [NDUT];
  logic [NDUT-1:0] ready_v, pin_v, busy_v, done_v;

  int checks   = 0;
  int failures = 0;
  bit exp_bits[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dw_of(input int i);   return (i == 3) ? 7 : 8;          endfunction
  function automatic int pen_of(input int i);  return (i == 1 || i == 2) ? 1 : 0; endfunction
  function automatic int podd_of(input int i); return (i == 2) ? 1 : 0;           endfunction
  function automatic int sb_of(input int i);   return (i == 3) ? 2 : 1;           endfunction
  function automatic int frame_len(input int i);
    return (1 + dw_of(i) + pen_of(i) + sb_of(i)) * CPB;
  endfunction

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int DW = (gi == 3) ? 7 : 8;
    uart_tx #(
      .UART_CLK_CNT(CPB),
      .data_width  (DW),
      .PARITY_EN   ((gi == 1 || gi == 2) ? 1 : 0),
      .PARITY_ODD  ((gi == 2) ? 1 : 0),
      .STOP_BITS   ((gi == 3) ? 2 : 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst_v[gi]),
      .tx_data    (data_v[gi][DW-1:0]),
      .tx_valid   (valid_v[gi]),
      .tx_ready   (ready_v[gi]),
      .uart_tx_pin(pin_v[gi]),
      .tx_busy    (busy_v[gi]),
      .tx_done    (done_v[gi])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference frame: list of line levels, one entry per bit time.
  function automatic void push_frame(input int i, input logic [8:0] d);
    int ones = 0;
    exp_bits.push_back(1'b0);
    for (int b = 0; b < dw_of(i); b++) begin
      exp_bits.push_back(d[b]);
      ones += int'(d[b]);
    end
    if (pen_of(i) != 0) exp_bits.push_back(bit'((ones % 2) ^ podd_of(i)));
    for (int s = 0; s < sb_of(i); s++) exp_bits.push_back(1'b1);
  endfunction

  task automatic check_idle(input int i, input string tag);
    check({tag, "_pin"},   128'(pin_v[i]),   128'(1));
    check({tag, "_ready"}, 128'(ready_v[i]), 128'(1));
    check({tag, "_busy"},  128'(busy_v[i]),  128'(0));
    check({tag, "_done"},  128'(done_v[i]),  128'(0));
  endtask

  // Sends nf (1 or 2) frames with tx_valid held, then checks whole-run waveforms.
  task automatic run_frames(input int i, input int nf, input logic [8:0] d0, input logic [8:0] d1);
    int L = frame_len(i);
    int total = nf * L;
    logic [127:0] pin_o = '0, pin_e = '0, done_o = '0, done_e = '0;
    logic [127:0] rdy_o = '0, rdy_e = '0, busy_o = '0, busy_e = '0;
    exp_bits.delete();
    push_frame(i, d0);
    if (nf > 1) push_frame(i, d1);
    @(negedge clk);
    check("ready_before", 128'(ready_v[i]), 128'(1));
    valid_v[i] = 1'b1;
    data_v[i]  = d0;
    for (int c = 1; c <= total; c++) begin
      @(posedge clk);
      @(negedge clk);
      pin_o[c-1]  = pin_v[i];
      done_o[c-1] = done_v[i];
      rdy_o[c-1]  = ready_v[i];
      busy_o[c-1] = busy_v[i];
      pin_e[c-1]  = exp_bits[(c-1) / CPB];
      done_e[c-1] = (c % L == 0);
      rdy_e[c-1]  = (c % L == 0);
      busy_e[c-1] = 1'b1;
      if ((c-1) % L == 0 && (c-1) / L < nf) begin
        if ((c-1) / L + 1 < nf) data_v[i] = d1;
        else begin
          valid_v[i] = 1'b0;
          data_v[i]  = 9'($urandom);
        end
      end
    end
    check("pin_wave",   pin_o,  pin_e);
    check("done_wave",  done_o, done_e);
    check("ready_wave", rdy_o,  rdy_e);
    check("busy_wave",  busy_o, busy_e);
    @(posedge clk);
    @(negedge clk);
    check_idle(i, "after");
    $display("frame dut=%0d frames=%0d d0=%h d1=%h cycles=%0d", i, nf, d0, d1, total);
  endtask

  // Reset asserted while DATA bit 3 is on the line.
  task automatic reset_mid_frame(input int i, input logic [8:0] d);
    int dones = 0;
    @(negedge clk);
    valid_v[i] = 1'b1;
    data_v[i]  = d;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) valid_v[i] = 1'b0;
      dones += int'(done_v[i]);
    end
    check("mid_bit3", 128'(pin_v[i]), 128'(d[3]));
    rst_v[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dones += int'(done_v[i]);
    check_idle(i, "midrst");
    check("midrst_nodone", 128'(dones), 128'(0));
    rst_v[i] = 1'b0;
    $display("midreset dut=%0d data=%h", i, d);
  endtask

  initial begin
    rst_v   = '1;
    valid_v = '0;
    for (int i = 0; i < NDUT; i++) data_v[i] = '0;

    valid_v[0] = 1'b1;
    data_v[0]  = 9'h0A5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) check_idle(i, "reset");
    valid_v[0] = 1'b0;
    rst_v = '0;
    @(posedge clk);
    @(negedge clk);
    check_idle(0, "post_reset");
    $display("reset checked");

    run_frames(0, 1, 9'h0A5, 9'h000);
    run_frames(0, 2, 9'h000, 9'h0FF);
    run_frames(1, 1, 9'h007, 9'h000);
    run_frames(2, 1, 9'h007, 9'h000);
    run_frames(3, 1, 9'h041, 9'h000);
    reset_mid_frame(0, 9'h05A);
    run_frames(0, 1, 9'($urandom), 9'h000);

    for (int t = 0; t < 8; t++) begin
      int i  = int'($urandom_range(0, NDUT - 1));
      int nf = int'($urandom_range(1, 2));
      run_frames(i, nf, 9'($urandom), 9'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
